apb_arbiter_master: RTL and testbench

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

---
 rtl/apb_arbiter_master.sv | 115 +++++++++++
 tb/tb_apb_arbiter_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Each granted transfer runs SETUP then ACCESS and is aborted after TIMEOUT_CYCLES waits.
module apb_arbiter_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [1:0]  req,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic [1:0]  fsm_state
);

  // Handshake: req[i] is a level held by requester i; the transfer is accepted when
  // SETUP starts and finishes with the one-cycle done[i] pulse carrying rsp_rdata/rsp_err.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [4:0] LAST_WAIT = 5'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       ptr;
  logic       winner;
  logic [4:0] wait_cnt;
  logic [1:0] eligible;
  logic       pick;

  assign fsm_state = state;

  // A requester whose done is high this cycle is masked so a held req is not re-granted.
  always_comb begin
    eligible = req & ~done;
    pick     = ptr;
    if (eligible == 2'b01) begin
      pick = 1'b0;
    end else if (eligible == 2'b10) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      winner    <= 1'b0;
      wait_cnt  <= 5'd0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'd0;
      pwdata    <= 32'd0;
      done      <= 2'b00;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      done      <= 2'b00;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            winner  <= pick;
            pwrite  <= pick ? req_write[1] : req_write[0];
            paddr   <= pick ? req_addr[63:32] : req_addr[31:0];
            pwdata  <= pick ? req_wdata[63:32] : req_wdata[31:0];
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= 5'd0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (pready || (wait_cnt == LAST_WAIT)) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            done    <= winner ? 2'b10 : 2'b01;
            ptr     <= ~winner;
            state   <= IDLE;
            if (pready) begin
              rsp_err   <= pslverr;
              rsp_rdata <= pwrite ? 32'd0 : prdata;
            end else begin
              // Timeout abort: flag an error with no data.
              rsp_err  <= 1'b1;
              wait_cnt <= wait_cnt + 5'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Bench for apb_arbiter_master: transaction-level reference model feeding expected queues,
// a wait-state APB slave, and a monitor that checks every SETUP and done pulse.
module tb_apb_arbiter_master;

  localparam int TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  req, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [1:0]  fsm_state;

  apb_arbiter_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [64:0] setup_q[$];   // {write, addr, wdata}
  logic [40:0] rsp_q[$];     // {done, rdata, err, access cycles}
  int          wait_q[$];
  logic [31:0] model_mem[64];
  logic [31:0] slave_mem[64];
  logic        model_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_err_addr(input logic [31:0] a);
    return (a >= 32'd40) && (a < 32'd48);
  endfunction

  // Reference model: one granted transfer by requester w with wt slave wait states.
  task automatic predict(input int w, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int wt);
    logic        err;
    logic [31:0] rd;
    int          len;
    if (wt >= TIMEOUT) begin
      err = 1'b1;
      rd  = 32'd0;
      len = TIMEOUT;
    end else begin
      len = wt + 1;
      err = is_err_addr(addr);
      if (wr) begin
        rd = 32'd0;
        if (!err) model_mem[addr[5:0]] = data;
      end else begin
        rd = err ? (32'hBAD0_0000 | addr) : model_mem[addr[5:0]];
      end
    end
    setup_q.push_back({wr, addr, data});
    rsp_q.push_back({(w == 1) ? 2'b10 : 2'b01, rd, err, 6'(len)});
    wait_q.push_back(wt);
    model_ptr = (w == 0);
  endtask

  // ---------------- APB slave ----------------
  int cur_wait = 0;
  int wcnt = 0;
  always @(negedge pclk) begin
    if (psel && !penable) begin
      cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      wcnt     = 0;
      pready   = 1'($urandom_range(0, 1));
      pslverr  = 1'($urandom_range(0, 1));
      prdata   = $urandom;
    end else if (psel && penable) begin
      if (wcnt == cur_wait) begin
        pready  = 1'b1;
        pslverr = is_err_addr(paddr);
        if (pwrite) begin
          prdata = $urandom;
          if (!pslverr) slave_mem[paddr[5:0]] = pwdata;
        end else begin
          prdata = pslverr ? (32'hBAD0_0000 | paddr) : slave_mem[paddr[5:0]];
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      wcnt++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end
  end

  // ---------------- monitor ----------------
  logic [64:0] se;
  logic [40:0] re;
  logic [5:0]  acc_len = 6'd0;
  always @(negedge pclk) begin
    if (presetn) begin
      if (psel && !penable) begin
        check("setup_expected", setup_q.size() > 0, 1);
        if (setup_q.size() > 0) begin
          se = setup_q.pop_front();
          check("pwrite", pwrite, se[64]);
          check("paddr", paddr, se[63:32]);
          check("pwdata", pwdata, se[31:0]);
        end
        acc_len = 6'd0;
      end
      if (psel && penable) acc_len = acc_len + 6'd1;
      check("done_onehot0", $countones(done) <= 1, 1);
      if (done != 2'b00) begin
        check("done_expected", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          re = rsp_q.pop_front();
          check("done_vec", done, re[40:39]);
          check("rsp_rdata", rsp_rdata, re[38:7]);
          check("rsp_err", rsp_err, re[6]);
          check("access_cycles", acc_len, re[5:0]);
        end
      end else begin
        check("idle_rsp_zero", {rsp_rdata, rsp_err}, 33'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int i, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
    req_write[i]        = wr;
    req_addr[i*32 +: 32]  = addr;
    req_wdata[i*32 +: 32] = data;
  endtask

  task automatic run_until_done(input logic [1:0] p, input logic drop);
    logic [1:0] pend;
    int         budget;
    pend   = p;
    budget = 0;
    req    = p;
    while (pend != 2'b00 && budget < 200) begin
      @(negedge pclk);
      budget++;
      if (drop && psel && !penable) req = 2'b00;
      pend = pend & ~done;
      req  = req & ~done;
    end
    if (pend != 2'b00) begin
      check("round_completion", pend, 2'b00);
      req = 2'b00;
    end
  endtask

  task automatic held_run(input logic [1:0] p, input int n, input int exp_gap);
    logic [31:0] d0;
    int          w, seen, last, cyc;
    d0 = $urandom;
    set_fields(0, 1'b1, 32'd7, d0);
    set_fields(1, 1'b0, 32'd7, 32'd0);
    for (int k = 0; k < n; k++) begin
      w = (p == 2'b11) ? (model_ptr ? 1 : 0) : ((p == 2'b10) ? 1 : 0);
      predict(w, (w == 0), 32'd7, (w == 0) ? d0 : 32'd0, 0);
    end
    req  = p;
    seen = 0;
    last = -1;
    cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge pclk);
      cyc++;
      if (done != 2'b00) begin
        seen++;
        if (last >= 0) check("done_gap", cyc - last, exp_gap);
        last = cyc;
        if (seen == n) req = 2'b00;
      end
    end
    if (seen < n) check("held_run_completion", seen, n);
    req = 2'b00;
  endtask

  task automatic random_round();
    logic [1:0]  p;
    logic        wr[2];
    logic [31:0] a[2], d[2];
    int          wt[2];
    int          first;
    logic        drop;
    p = 2'($urandom_range(1, 3));
    for (int i = 0; i < 2; i++) begin
      wr[i] = 1'($urandom_range(0, 1));
      a[i]  = $urandom_range(0, 63);
      d[i]  = $urandom;
      wt[i] = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 3);
      set_fields(i, wr[i], a[i], d[i]);
    end
    first = (p == 2'b11) ? (model_ptr ? 1 : 0) : ((p == 2'b10) ? 1 : 0);
    predict(first, wr[first], a[first], d[first], wt[first]);
    if (p == 2'b11) predict(1 - first, wr[1-first], a[1-first], d[1-first], wt[1-first]);
    drop = (p != 2'b11) && ($urandom_range(0, 1) == 1);
    run_until_done(p, drop);
    repeat ($urandom_range(0, 3)) @(negedge pclk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b;
    presetn   = 1'b0;
    req       = 2'b00;
    req_write = 2'b00;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'd0;
    model_ptr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 32'd0;
      slave_mem[i] = 32'd0;
    end
    repeat (3) @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    presetn = 1'b1;
    @(negedge pclk);

    // single write, read-back, slave error, timeout
    set_fields(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    predict(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0);
    run_until_done(2'b01, 1'b0);
    set_fields(1, 1'b0, 32'd5, 32'd0);
    predict(1, 1'b0, 32'd5, 32'd0, 0);
    run_until_done(2'b10, 1'b0);
    set_fields(0, 1'b0, 32'd40, 32'd0);
    predict(0, 1'b0, 32'd40, 32'd0, 1);
    run_until_done(2'b01, 1'b0);
    set_fields(1, 1'b1, 32'd12, 32'h1234_5678);
    predict(1, 1'b1, 32'd12, 32'h1234_5678, 99);
    run_until_done(2'b10, 1'b0);

    // contention held through done, then a single held request
    held_run(2'b11, 4, 3);
    held_run(2'b01, 3, 4);

    // asynchronous reset in the middle of ACCESS
    set_fields(0, 1'b0, 32'd20, 32'd0);
    set_fields(1, 1'b0, 32'd21, 32'd0);
    predict(model_ptr ? 1 : 0, 1'b0, model_ptr ? 32'd21 : 32'd20, 32'd0, 6);
    predict(model_ptr ? 1 : 0, 1'b0, model_ptr ? 32'd21 : 32'd20, 32'd0, 6);
    req = 2'b11;
    b = 0;
    do begin
      @(negedge pclk);
      b++;
    end while (!(psel && penable) && b < 50);
    check("reached_access", psel && penable, 1);
    repeat (2) @(negedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    check("async_rst_done", done, 0);
    setup_q.delete();
    rsp_q.delete();
    wait_q.delete();
    model_ptr = 1'b0;
    predict(0, 1'b0, 32'd20, 32'd0, 0);
    predict(1, 1'b0, 32'd21, 32'd0, 0);
    @(negedge pclk);
    presetn = 1'b1;
    run_until_done(2'b11, 1'b0);

    // randomized traffic
    for (int r = 0; r < 60; r++) random_round();

    repeat (5) @(negedge pclk);
    check("setup_q_drained", setup_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
